// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive deserialiser.
package spi_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

    localparam int D_PACK_MIN = 2;
    localparam int D_PACK_MAX = 32;

    // Bit-counter width for a frame of d_pack bits, with d_pack clamped to the legal range.
    function automatic int cnt_width(input int d_pack);
        int d;
        d = (d_pack < D_PACK_MIN) ? D_PACK_MIN : ((d_pack > D_PACK_MAX) ? D_PACK_MAX : d_pack);
        return $clog2(d);
    endfunction

endpackage

// File: rtl/spi_edge_det.sv
// Edge detector for an oversampled serial clock; optional 2-flop synchroniser under SPI_RX_SYNC_EN.
module spi_edge_det (
    input  logic clk,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic level_s;
    logic dly_r;

`ifdef SPI_RX_SYNC_EN
    logic [1:0] sync_r;

    // Two-flop synchroniser; left unreset so no artificial edge appears at reset release.
    always_ff @(posedge clk) begin
        sync_r <= {sync_r[0], sig};
    end

    assign level_s = sync_r[1];
`else
    assign level_s = sig;
`endif

    // One-cycle delayed copy; it tracks the input during reset too, so no false edge follows release.
    always_ff @(posedge clk) begin
        dly_r <= level_s;
    end

    assign rise = level_s & ~dly_r;
    assign fall = ~level_s & dly_r;

endmodule

// File: rtl/spi_rx_deser.sv
// SPI slave receive deserialiser: oversamples SCK on CLK and assembles D_PACK-bit frames.
// Optional input synchronisers are enabled with the SPI_RX_SYNC_EN macro.
module spi_rx_deser
    import spi_pkg::*;
#(
    parameter int D_PACK    = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SCK,
    input  logic              DATA_IN,
    input  logic              CS_N,
    input  logic              C_POL,
    input  logic              C_PH,
    input  logic              READY,
    input  logic              OVR_CLR,
    output logic [D_PACK-1:0] PAR_OUT,
    output logic              VALID,
    output logic              BUSY,
    output logic              OVERRUN,
    output logic              FRAME_ERR
);

    localparam int                CNT_W    = cnt_width(D_PACK);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(D_PACK - 1);

    spi_state_t        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [D_PACK-1:0] shreg_r;
    logic [D_PACK-1:0] par_r;
    logic              valid_r;
    logic              busy_r;
    logic              overrun_r;
    logic              frame_err_r;

    logic              sck_rise_s;
    logic              sck_fall_s;
    logic              data_s;
    logic              cs_s;
    logic              sample_s;
    logic              complete_s;
    logic [CNT_W-1:0]  idx_s;
    logic [D_PACK-1:0] word_s;

`ifdef SPI_RX_SYNC_EN
    logic [1:0] data_sync_r;
    logic [1:0] cs_sync_r;

    // Synchronise data and select alongside SCK so all three keep the same latency.
    always_ff @(posedge CLK) begin
        data_sync_r <= {data_sync_r[0], DATA_IN};
        cs_sync_r   <= {cs_sync_r[0], CS_N};
    end

    assign data_s = data_sync_r[1];
    assign cs_s   = cs_sync_r[1];
`else
    assign data_s = DATA_IN;
    assign cs_s   = CS_N;
`endif

    spi_edge_det u_sck_edge (
        .clk  (CLK),
        .sig  (SCK),
        .rise (sck_rise_s),
        .fall (sck_fall_s)
    );

    // Sampling-edge selection, bit placement and frame-completion decode.
    always_comb begin
        sample_s   = (C_POL == C_PH) ? sck_rise_s : sck_fall_s;
        idx_s      = (LSB_FIRST != 0) ? cnt_r : (LAST_IDX - cnt_r);
        word_s     = shreg_r;
        word_s[idx_s] = data_s;
        complete_s = (state_r == SHIFT) && !cs_s && sample_s && (cnt_r == LAST_IDX);
    end

    // Frame FSM, shift register, output word and status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            shreg_r     <= {D_PACK{1'b0}};
            par_r       <= {D_PACK{1'b0}};
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (!cs_s) begin
                        state_r <= SHIFT;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_s) begin
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        cnt_r       <= {CNT_W{1'b0}};
                        shreg_r     <= {D_PACK{1'b0}};
                        frame_err_r <= (cnt_r != {CNT_W{1'b0}});
                    end else if (sample_s) begin
                        shreg_r <= word_s;
                        cnt_r   <= (cnt_r == LAST_IDX) ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase

            // A completing frame may replace the word only if the old one is gone or being taken now.
            if (complete_s && (!valid_r || READY)) begin
                par_r   <= word_s;
                valid_r <= 1'b1;
            end else if (valid_r && READY) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end

            if (complete_s && valid_r && !READY) begin
                overrun_r <= 1'b1;
            end else if (OVR_CLR) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign PAR_OUT   = par_r;
    assign VALID     = valid_r;
    assign BUSY      = busy_r;
    assign OVERRUN   = overrun_r;
    assign FRAME_ERR = frame_err_r;

endmodule

// File: tb/tb_spi_rx_deser.sv
// Directed self-checking bench for spi_rx_deser (8-bit LSB-first and 16-bit MSB-first instances).
module tb_spi_rx_deser;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SCK = 1'b0;
    logic        DATA_IN = 1'b0;
    logic        CS_N = 1'b1;
    logic        C_POL = 1'b0;
    logic        C_PH = 1'b0;
    logic        READY = 1'b1;
    logic        OVR_CLR = 1'b0;

    logic [7:0]  par8;
    logic        valid8, busy8, ovr8, ferr8;
    logic [15:0] par16;
    logic        valid16, busy16, ovr16, ferr16;

    int checks = 0;
    int failures = 0;

    int          vcnt8 = 0, fe8 = 0, vcnt16 = 0, fe16 = 0;
    logic [31:0] last8 = 32'h0, last16 = 32'h0;

    always #5 CLK = ~CLK;

    spi_rx_deser #(.D_PACK(8), .LSB_FIRST(1)) dut8 (
        .CLK(CLK), .RST(RST), .SCK(SCK), .DATA_IN(DATA_IN), .CS_N(CS_N),
        .C_POL(C_POL), .C_PH(C_PH), .READY(READY), .OVR_CLR(OVR_CLR),
        .PAR_OUT(par8), .VALID(valid8), .BUSY(busy8), .OVERRUN(ovr8), .FRAME_ERR(ferr8)
    );

    spi_rx_deser #(.D_PACK(16), .LSB_FIRST(0)) dut16 (
        .CLK(CLK), .RST(RST), .SCK(SCK), .DATA_IN(DATA_IN), .CS_N(CS_N),
        .C_POL(C_POL), .C_PH(C_PH), .READY(READY), .OVR_CLR(OVR_CLR),
        .PAR_OUT(par16), .VALID(valid16), .BUSY(busy16), .OVERRUN(ovr16), .FRAME_ERR(ferr16)
    );

    // Output monitor sampled 1 time unit after each rising edge.
    always begin
        @(posedge CLK);
        #1;
        if (valid8)  begin vcnt8++;  last8  = {24'h0, par8};  end
        if (valid16) begin vcnt16++; last16 = {16'h0, par16}; end
        if (ferr8)   fe8++;
        if (ferr16)  fe16++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clr_mon();
        vcnt8 = 0; fe8 = 0; vcnt16 = 0; fe16 = 0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input bit msb);
        for (int i = 0; i < n; i++) begin
            logic b;
            b = msb ? w[n-1-i] : w[i];
            if (!C_PH) begin
                DATA_IN = b;
                cyc(2);
                SCK = ~C_POL;
                cyc(2);
                SCK = C_POL;
            end else begin
                SCK = ~C_POL;
                DATA_IN = b;
                cyc(2);
                SCK = C_POL;
                cyc(2);
            end
        end
        cyc(2);
    endtask

    initial begin
        // Reset state
        cyc(3);
        chk("rst_par8", {24'h0, par8}, 32'h0);
        chk("rst_valid8", {31'h0, valid8}, 32'h0);
        chk("rst_busy8", {31'h0, busy8}, 32'h0);
        chk("rst_ovr8", {31'h0, ovr8}, 32'h0);
        chk("rst_ferr8", {31'h0, ferr8}, 32'h0);
        chk("rst_par16", {16'h0, par16}, 32'h0);
        RST = 1'b0;
        cyc(2);

        // Mode 0, 0xA5 LSB first, READY high
        clr_mon();
        CS_N = 1'b0;
        cyc(2);
        chk("m0_busy", {31'h0, busy8}, 32'h1);
        send_bits(32'hA5, 8, 1'b0);
        CS_N = 1'b1;
        cyc(3);
        chk("m0_par", {24'h0, par8}, 32'hA5);
        chk("m0_valid_cycles", vcnt8, 32'd1);
        chk("m0_valid_now", {31'h0, valid8}, 32'h0);
        chk("m0_busy_idle", {31'h0, busy8}, 32'h0);
        chk("m0_no_ferr", fe8, 32'd0);

        // Mode 3, 0x1234 MSB first into the 16-bit instance
        C_POL = 1'b1; C_PH = 1'b1; SCK = 1'b1; RST = 1'b1;
        cyc(2);
        RST = 1'b0;
        cyc(2);
        clr_mon();
        CS_N = 1'b0;
        cyc(2);
        send_bits(32'h1234, 16, 1'b1);
        CS_N = 1'b1;
        cyc(3);
        chk("m3_par16", {16'h0, par16}, 32'h1234);
        chk("m3_valid16_cycles", vcnt16, 32'd1);
        chk("m3_no_ferr16", fe16, 32'd0);
        chk("m3_par8_second_byte", {24'h0, par8}, 32'h2C);
        chk("m3_valid8_cycles", vcnt8, 32'd2);

        // READY low, back-to-back 0x11 then 0x22: overrun, first word kept
        C_POL = 1'b0; C_PH = 1'b0; SCK = 1'b0;
        cyc(2);
        READY = 1'b0;
        CS_N = 1'b0;
        cyc(2);
        send_bits(32'h11, 8, 1'b0);
        send_bits(32'h22, 8, 1'b0);
        CS_N = 1'b1;
        cyc(3);
        chk("ovr_par", {24'h0, par8}, 32'h11);
        chk("ovr_valid", {31'h0, valid8}, 32'h1);
        chk("ovr_set", {31'h0, ovr8}, 32'h1);
        chk("ovr_par16", {16'h0, par16}, 32'h8844);
        OVR_CLR = 1'b1;
        cyc(1);
        OVR_CLR = 1'b0;
        chk("ovr_clr", {31'h0, ovr8}, 32'h0);
        chk("ovr_clr_valid_kept", {31'h0, valid8}, 32'h1);
        READY = 1'b1;
        cyc(2);
        chk("ovr_drain", {31'h0, valid8}, 32'h0);

        // Truncated frame after 5 bits, then a full 0x3C
        clr_mon();
        CS_N = 1'b0;
        cyc(2);
        send_bits(32'h1F, 5, 1'b0);
        CS_N = 1'b1;
        cyc(3);
        chk("ferr_pulse", fe8, 32'd1);
        chk("ferr_no_valid", vcnt8, 32'd0);
        CS_N = 1'b0;
        cyc(2);
        send_bits(32'h3C, 8, 1'b0);
        CS_N = 1'b1;
        cyc(3);
        chk("ferr_next_par", last8, 32'h3C);
        chk("ferr_next_valid", vcnt8, 32'd1);
        chk("ferr_next_no_err", fe8, 32'd1);

        // Reset after 3 bits, then 0xF0
        clr_mon();
        CS_N = 1'b0;
        cyc(2);
        send_bits(32'h07, 3, 1'b0);
        RST = 1'b1;
        cyc(2);
        chk("mrst_par", {24'h0, par8}, 32'h0);
        chk("mrst_busy", {31'h0, busy8}, 32'h0);
        chk("mrst_valid", {31'h0, valid8}, 32'h0);
        RST = 1'b0;
        cyc(2);
        CS_N = 1'b1;
        cyc(2);
        CS_N = 1'b0;
        cyc(2);
        send_bits(32'hF0, 8, 1'b0);
        CS_N = 1'b1;
        cyc(3);
        chk("mrst_next_par", {24'h0, par8}, 32'hF0);
        chk("mrst_no_ferr", fe8, 32'd0);
        chk("mrst_ovr", {31'h0, ovr8}, 32'h0);

        // Completion in the same cycle as the handshake
        READY = 1'b0;
        CS_N = 1'b0;
        cyc(2);
        send_bits(32'h5A, 8, 1'b0);
        chk("hs_first_par", {24'h0, par8}, 32'h5A);
        send_bits(32'hC3, 7, 1'b0);
        DATA_IN = 1'b1;
        cyc(2);
        SCK = 1'b1;
        READY = 1'b1;
        cyc(1);
        READY = 1'b0;
        chk("hs_new_par", {24'h0, par8}, 32'hC3);
        chk("hs_valid", {31'h0, valid8}, 32'h1);
        chk("hs_no_ovr", {31'h0, ovr8}, 32'h0);
        cyc(1);
        SCK = 1'b0;
        cyc(2);
        CS_N = 1'b1;
        cyc(2);
        chk("hs_valid_held", {31'h0, valid8}, 32'h1);
        READY = 1'b1;
        cyc(2);
        chk("hs_drain", {31'h0, valid8}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_rx_deser.md
SPI_RX_DESER -- requirements
Module: spi_rx_deser

Interface
REQ-001 The block SHALL have parameter D_PACK, default 8, meaning the frame width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter LSB_FIRST, default 1, meaning the first received bit lands in PAR_OUT[0]; 0 means it lands in PAR_OUT[D_PACK-1].
REQ-003 The block SHALL have port CLK, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port SCK, input, 1 bit: SPI serial clock, asynchronous to CLK, oversampled.
REQ-006 The block SHALL have port DATA_IN, input, 1 bit: serial data (MOSI).
REQ-007 The block SHALL have port CS_N, input, 1 bit: active-low frame select.
REQ-008 The block SHALL have ports C_POL and C_PH, input, 1 bit each: SPI clock polarity and phase.
REQ-009 The block SHALL have port READY, input, 1 bit: downstream accepts PAR_OUT.
REQ-010 The block SHALL have port OVR_CLR, input, 1 bit: clears OVERRUN.
REQ-011 The block SHALL have port PAR_OUT, output, D_PACK bits: the last completed frame.
REQ-012 The block SHALL have port VALID, output, 1 bit: PAR_OUT holds an unconsumed frame.
REQ-013 The block SHALL have port BUSY, output, 1 bit: the block is in state SHIFT.
REQ-014 The block SHALL have port OVERRUN, output, 1 bit: sticky; a frame was dropped.
REQ-015 The block SHALL have port FRAME_ERR, output, 1 bit: one-cycle pulse; a frame was truncated.

Function
REQ-016 The block SHALL detect a sampling edge in the cycle where the (synchronised) SCK differs from its one-cycle-delayed copy in the direction: rising when C_POL==C_PH, falling otherwise.
REQ-017 The block SHALL ignore the opposite (shift) edge of SCK.
REQ-018 The FSM SHALL have states IDLE and SHIFT: IDLE->SHIFT when CS_N==0; SHIFT->IDLE when CS_N==1.
REQ-019 In SHIFT, the block SHALL write the DATA_IN bit into the shift register at the index given by the bit counter (or D_PACK-1-counter when LSB_FIRST==0) and increment the counter on each sampling edge.
REQ-020 On the D_PACK-th sampling edge, the counter SHALL wrap to 0, the block SHALL stay in SHIFT, and it SHALL stream back-to-back frames while CS_N stays low.
REQ-021 Frame completion SHALL copy the assembled word into PAR_OUT and set VALID, both visible 1 CLK after the completing edge cycle.
REQ-022 When VALID==1 and READY==1 in a cycle, VALID SHALL clear next cycle unless a frame completes in the same cycle.
REQ-023 If completion and handshake occur in the same cycle, the new word SHALL load and VALID SHALL remain 1.
REQ-024 If completion occurs while VALID==1 and READY==0, the new word SHALL be discarded, PAR_OUT SHALL be unchanged, and OVERRUN SHALL set.
REQ-025 OVERRUN SHALL clear on OVR_CLR; a simultaneous set and clear SHALL leave OVERRUN set.
REQ-026 If CS_N rises with counter!=0, the partial word SHALL be discarded, the counter SHALL go to 0, and FRAME_ERR SHALL pulse for 1 cycle.
REQ-027 If CS_N rises with counter==0, no error SHALL be raised.
REQ-028 Sampling edges in IDLE SHALL have no effect.
REQ-029 C_POL and C_PH SHALL be changed only while the block is in IDLE; a change while in SHIFT gives undefined frame content but SHALL NOT corrupt the FSM.

Reset
REQ-030 During RST, the block SHALL hold: state=IDLE, counter=0, shift register=0, PAR_OUT=0, VALID=0, BUSY=0, OVERRUN=0, FRAME_ERR=0.
REQ-031 During RST, the delayed-SCK register SHALL load the current (synchronised) SCK so that no false edge is seen after reset release.
REQ-032 RST asserted mid-frame SHALL discard the partial word and SHALL NOT pulse FRAME_ERR.

Configuration
REQ-033 With SPI_RX_SYNC_EN defined, SCK, DATA_IN and CS_N SHALL each pass through a 2-flop synchroniser, adding 2 CLK of latency to every event.
REQ-034 Without SPI_RX_SYNC_EN, these inputs SHALL be used directly (for synchronous test harnesses), and REQ-021 latency SHALL be measured from the raw edge.

Structure
REQ-035 Package spi_pkg SHALL hold the FSM state typedef (IDLE, SHIFT) and the D_PACK range constants.
REQ-036 The block SHALL contain one sub-module, spi_edge_det, comprising the optional synchroniser, the delayed register and the rise/fall detection, instantiated once for SCK.

Verification
REQ-037 The bench SHALL cover: mode 0, D_PACK=8, LSB_FIRST=1, send 0xA5 with READY=1 -> PAR_OUT=0xA5 and VALID for 1 cycle.
REQ-038 The bench SHALL cover: mode 3, LSB_FIRST=0, D_PACK=16, send 0x1234 MSB first -> PAR_OUT=0x1234.
REQ-039 The bench SHALL cover: READY=0, two back-to-back frames 0x11 then 0x22 -> PAR_OUT=0x11 and OVERRUN=1; OVR_CLR -> OVERRUN=0.
REQ-040 The bench SHALL cover: CS_N raised after 5 bits -> FRAME_ERR one pulse, VALID stays 0; the next full frame 0x3C is received correctly.
REQ-041 The bench SHALL cover: RST asserted after 3 bits of a frame -> all outputs 0, no FRAME_ERR; a subsequent frame 0xF0 is received correctly.
REQ-042 The bench SHALL cover: completion in the same cycle as VALID&READY -> the new word is loaded, VALID stays 1, OVERRUN stays 0.
